// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI master write-command scheduler.
package axi_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } sched_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ID_WIDTH    = 4;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_ptr, wrapping.
module axi_rr_pick
    import axi_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        winner   = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any              = 1'b1;
                idx              = cand_idx;
                winner[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_master_wr_sched.sv
// Round-robin scheduler sharing the AXI master write-command port among NUM_REQ requesters.
// Optional response watchdog: define AXI_WR_SCHED_TIMEOUT_EN.
module axi_master_wr_sched
    import axi_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          AClk,
    input  logic                          ARst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    input  logic [NUM_REQ*3-1:0]          req_size,
    input  logic [NUM_REQ*2-1:0]          req_burst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*8-1:0]          req_wstrb,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            owner,
    output logic [NUM_REQ-1:0]            done,
    output logic [1:0]                    done_resp,
    output logic                          err,
    output logic [ID_WIDTH-1:0]           TXN_ID_W_d,
    output logic [ADDR_WIDTH-1:0]         awaddr_d,
    output logic [7:0]                    awlen_d,
    output logic [2:0]                    awsize_d,
    output logic [1:0]                    awburst_d,
    output logic [DATA_WIDTH-1:0]         wdata_d,
    output logic [7:0]                    wstrb_d,
    output logic                          wr_trn_en,
    input  logic [1:0]                    bresp_d,
    input  logic [ID_WIDTH-1:0]           bid_d,
    input  logic                          wr_rsp_en_d
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_e state, state_nxt;

    logic [IDX_W-1:0]   last_ptr;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic               start;
    logic               rsp_accept;
    logic               stray_rsp;
    logic               timeout_hit;

    logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
    logic [7:0]            len_a   [NUM_REQ];
    logic [2:0]            size_a  [NUM_REQ];
    logic [1:0]            burst_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];
    logic [7:0]            wstrb_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign len_a[i]   = req_len[i*8 +: 8];
        assign size_a[i]  = req_size[i*3 +: 3];
        assign burst_a[i] = req_burst[i*2 +: 2];
        assign wdata_a[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_a[i] = req_wstrb[i*8 +: 8];
    end

    axi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req      (req),
        .last_ptr (last_ptr),
        .winner   (pick_oh),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    // Arbitration is held off during the done pulse so a requester sees its
    // completion before it can win again; next wr_trn_en is then at k+3.
    assign start      = (state == IDLE) && pick_any && !(|done);
    assign rsp_accept = (state == WAIT_RSP) && wr_rsp_en_d;
    assign stray_rsp  = (state != WAIT_RSP) && wr_rsp_en_d;

`ifdef AXI_WR_SCHED_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) begin
            tmo_cnt <= '0;
        end else if (state == ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_RSP) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // A response in the expiry cycle wins over the watchdog.
    assign timeout_hit = (state == WAIT_RSP) && !wr_rsp_en_d &&
                         (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    logic [15:0] unused_tmo;
    assign unused_tmo  = 16'(TIMEOUT_CYCLES);
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ISSUE;
            ISSUE:    state_nxt = WAIT_RSP;
            WAIT_RSP: if (rsp_accept || timeout_hit) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AClk or posedge ARst) begin
        if (ARst) begin
            last_ptr   <= IDX_W'(NUM_REQ - 1);
            idx_q      <= '0;
            owner      <= '0;
            done       <= '0;
            done_resp  <= RESP_OKAY;
            err        <= 1'b0;
            TXN_ID_W_d <= '0;
            awaddr_d   <= '0;
            awlen_d    <= '0;
            awsize_d   <= '0;
            awburst_d  <= '0;
        end else begin
            done      <= '0;
            done_resp <= RESP_OKAY;
            if (start) begin
                owner      <= pick_oh;
                idx_q      <= pick_idx;
                TXN_ID_W_d <= ID_WIDTH'(pick_idx);
                awaddr_d   <= addr_a[pick_idx];
                awlen_d    <= len_a[pick_idx];
                awsize_d   <= size_a[pick_idx];
                awburst_d  <= burst_a[pick_idx];
            end
            if (state == ISSUE) begin
                last_ptr <= idx_q;
            end
            if (rsp_accept) begin
                done      <= owner;
                done_resp <= bresp_d;
                owner     <= '0;
                if (bid_d != TXN_ID_W_d) begin
                    err <= 1'b1;
                end
            end else if (timeout_hit) begin
                done      <= owner;
                done_resp <= RESP_SLVERR;
                owner     <= '0;
                err       <= 1'b1;
            end
            if (stray_rsp) begin
                err <= 1'b1;
            end
        end
    end

    assign wr_trn_en = (state == ISSUE);
    assign gnt       = (state == ISSUE) ? owner : '0;
    assign wdata_d   = (|owner) ? wdata_a[idx_q] : '0;
    assign wstrb_d   = (|owner) ? wstrb_a[idx_q] : '0;

endmodule
